// File: rtl/rst_sequencer.sv
// Reset sequencer: releases NumDomains active-low resets one at a time, HoldCycles apart,
// and replays the sequence on an accepted req/ack re-reset. Optional checks: RST_SEQ_CHECKS_EN.
module rst_sequencer #(
    parameter int NumDomains = 4,
    parameter int HoldCycles = 8,
    parameter int CntWidth   = $clog2(HoldCycles + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  ack_o,
    output logic [NumDomains-1:0] rst_no,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int IdxWidth = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [0:0] HOLD = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(HoldCycles - 1);
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NumDomains - 1);

    logic [0:0]          state;
    logic [IdxWidth-1:0] idx;
    logic [CntWidth-1:0] cnt;

    // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values
    // independent of statement order inside the block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= HOLD;
            idx    <= '0;
            cnt    <= '0;
            rst_no <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt != CntLast) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        rst_no[idx] <= 1'b1;
                        cnt         <= '0;
                        if (idx == IdxLast) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    // An accepted re-reset asserts every domain and replays from the first one.
                    if (req_i) begin
                        rst_no <= '0;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= HOLD;
                    end
                end
            endcase
        end
    end

    assign done_o = (state == DONE);
    assign busy_o = ~done_o;
    assign ack_o  = done_o & req_i;

`ifdef RST_SEQ_CHECKS_EN
    if (NumDomains < 1) begin : g_bad_domains
        $fatal(1, "rst_sequencer: NumDomains must be >= 1");
    end
    if (HoldCycles < 1) begin : g_bad_hold
        $fatal(1, "rst_sequencer: HoldCycles must be >= 1");
    end

    // A released domain must never sit above a domain that is still held in reset.
    a_thermometer: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((rst_no >> 1) & ~rst_no) == '0)
        else $error("rst_sequencer: rst_no not thermometer-coded: %b", rst_no);

    a_ack_in_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ack_o |-> (state == DONE))
        else $error("rst_sequencer: ack_o asserted outside DONE");

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !ack_o) |=> req_i)
        else $error("rst_sequencer: req_i dropped before ack_o");
`endif

endmodule
